// File: rtl/branch_recovery_unit.sv
// Branch recovery: remembers the not-predicted PC per tag, tracks CDB resolution and runs the
// flush/redirect sequence when the predictor reports a mispredict on a freshly resolved branch.
module branch_recovery_unit #(
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rec_valid,
  input  logic [TAG_W-1:0]  rec_tag,
  input  logic [31:0]       rec_alt_pc,
  input  logic [73:0]       cdb,
  input  logic [TAG_W:0]    mis_tag,
  output logic              flush,
  output logic              fetch_stall,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [CNT_W-1:0]  mispredict_count,
  output logic              orphan_mis
);

  localparam int unsigned Depth = 2 ** TAG_W;

  typedef enum logic [1:0] {EntEmpty, EntPending, EntResolved} ent_e;
  typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  ent_e              ent_q [Depth];
  ent_e              ent_d [Depth];
  logic [31:0]       alt_q [Depth];
  logic              rec_we;
  logic              accept;
  logic              orphan_d;
  logic [TAG_W-1:0]  mis_idx;
  logic [TAG_W-1:0]  cdb_tag;
  logic [31:0]       redirect_pc_d;
  logic [CNT_W-1:0]  count_d;

  // Only valid and tag of the CDB matter here; the value field is ignored.
  logic unused_cdb;
  assign unused_cdb = ^{cdb[73:37], cdb[31:0]};

  assign mis_idx = mis_tag[TAG_W-1:0];
  assign cdb_tag = cdb[32 +: TAG_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ent_d    = ent_q;
    rec_we   = 1'b0;
    accept   = 1'b0;
    orphan_d = 1'b0;

    // RESOLVED survives one cycle only: exactly the window in which the predictor's tag lands.
    for (int i = 0; i < Depth; i++) begin
      if (ent_q[i] == EntResolved) begin
        ent_d[i] = EntEmpty;
      end
      if (cdb[36] && cdb_tag == TAG_W'(i) && ent_q[i] == EntPending) begin
        ent_d[i] = EntResolved;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (rec_valid) begin
          ent_d[rec_tag] = EntPending;
          rec_we         = 1'b1;
        end
        if (mis_tag[TAG_W]) begin
          if (ent_q[mis_idx] == EntResolved) begin
            accept  = 1'b1;
            state_d = StFlush;
            cnt_d   = 3'd0;
          end else begin
            orphan_d = 1'b1;
          end
        end
      end
      StFlush: begin
        for (int i = 0; i < Depth; i++) begin
          ent_d[i] = EntEmpty;
        end
        if (cnt_q == 3'(FLUSH_CYCLES - 1)) begin
          state_d = StRedirect;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StRedirect: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    redirect_pc_d = accept ? alt_q[mis_idx] : redirect_pc;
    count_d       = (accept && mispredict_count != '1) ? mispredict_count + 1'b1
                                                       : mispredict_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      cnt_q            <= 3'd0;
      flush            <= 1'b0;
      fetch_stall      <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= 32'd0;
      mispredict_count <= '0;
      orphan_mis       <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        ent_q[i] <= EntEmpty;
      end
    end else if (rdy) begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      flush            <= (state_d == StFlush);
      fetch_stall      <= (state_d != StIdle);
      redirect_valid   <= (state_d == StRedirect);
      redirect_pc      <= redirect_pc_d;
      mispredict_count <= count_d;
      orphan_mis       <= orphan_d;
      ent_q            <= ent_d;
    end
  end

  // PC storage needs no reset: an EMPTY entry's PC is never used.
  always_ff @(posedge clk) begin
    if (!rst && rdy && rec_we) begin
      alt_q[rec_tag] <= rec_alt_pc;
    end
  end

endmodule

// File: tb/tb_branch_recovery_unit.sv
// Directed bench for branch_recovery_unit: FLUSH_CYCLES=1 and 3 instances plus a narrow-counter
// instance for saturation; expected redirect PCs are queued at mispredict time.
module tb_branch_recovery_unit;

  logic        clk = 1'b0;
  logic        rst, rdy, rdy3, rec_valid;
  logic [3:0]  rec_tag;
  logic [31:0] rec_alt_pc;
  logic [73:0] cdb;
  logic [4:0]  mis_tag;

  logic        f1, st1, rv1, orph1;
  logic [31:0] pc1;
  logic [15:0] cnt1;
  logic        fs, sts, rvs, orphs;
  logic [31:0] pcs;
  logic [3:0]  cnts;
  logic        f3, st3, rv3, orph3;
  logic [31:0] pc3;
  logic [15:0] cnt3;

  int          n_pass = 0;
  int          n_checks = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  branch_recovery_unit #(.TAG_W(4), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .rdy(rdy), .rec_valid(rec_valid), .rec_tag(rec_tag),
    .rec_alt_pc(rec_alt_pc), .cdb(cdb), .mis_tag(mis_tag), .flush(f1), .fetch_stall(st1),
    .redirect_valid(rv1), .redirect_pc(pc1), .mispredict_count(cnt1), .orphan_mis(orph1)
  );

  branch_recovery_unit #(.TAG_W(4), .FLUSH_CYCLES(1), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .rdy(rdy), .rec_valid(rec_valid), .rec_tag(rec_tag),
    .rec_alt_pc(rec_alt_pc), .cdb(cdb), .mis_tag(mis_tag), .flush(fs), .fetch_stall(sts),
    .redirect_valid(rvs), .redirect_pc(pcs), .mispredict_count(cnts), .orphan_mis(orphs)
  );

  branch_recovery_unit #(.TAG_W(4), .FLUSH_CYCLES(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .rdy(rdy3), .rec_valid(rec_valid), .rec_tag(rec_tag),
    .rec_alt_pc(rec_alt_pc), .cdb(cdb), .mis_tag(mis_tag), .flush(f3), .fetch_stall(st3),
    .redirect_valid(rv3), .redirect_pc(pc3), .mispredict_count(cnt3), .orphan_mis(orph3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_ctl(input string tag, input int which, input logic fl, input logic st,
                         input logic rv, input logic orp);
    if (which == 3) begin
      chk({tag, ".flush3"}, 32'(f3), 32'(fl));
      chk({tag, ".stall3"}, 32'(st3), 32'(st));
      chk({tag, ".rv3"}, 32'(rv3), 32'(rv));
      chk({tag, ".orphan3"}, 32'(orph3), 32'(orp));
    end else begin
      chk({tag, ".flush"}, 32'(f1), 32'(fl));
      chk({tag, ".stall"}, 32'(st1), 32'(st));
      chk({tag, ".rv"}, 32'(rv1), 32'(rv));
      chk({tag, ".orphan"}, 32'(orph1), 32'(orp));
      chk({tag, ".flush_s"}, 32'(fs), 32'(fl));
      chk({tag, ".rv_s"}, 32'(rvs), 32'(rv));
    end
  endtask

  // Called in the first FLUSH cycle; walks FLUSH, REDIRECT and the return to IDLE.
  task automatic check_seq(input int which, input int fc);
    logic [31:0] exp_pc;
    for (int k = 0; k < fc; k++) begin
      chk_ctl("flush_phase", which, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk_ctl("redirect_phase", which, 1'b0, 1'b1, 1'b1, 1'b0);
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard: observed empty queue expected one pending redirect");
    end else begin
      exp_pc = exp_q.pop_front();
      chk("redirect_pc", (which == 3) ? pc3 : pc1, exp_pc);
      if (which != 3) chk("redirect_pc_s", pcs, exp_pc);
    end
    tick();
    chk_ctl("idle_after", which, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [73:0] cdb_word(input logic [3:0] t);
    logic [73:0] w;
    w         = '0;
    w[36]     = 1'b1;
    w[35:32]  = t;
    w[31:0]   = 32'd1;
    return w;
  endfunction

  task automatic record(input logic [3:0] t, input logic [31:0] pc);
    rec_valid  = 1'b1;
    rec_tag    = t;
    rec_alt_pc = pc;
    tick();
    rec_valid  = 1'b0;
  endtask

  task automatic resolve(input logic [3:0] t);
    cdb = cdb_word(t);
    tick();
    cdb = '0;
  endtask

  task automatic mispredict(input logic [3:0] t);
    mis_tag = {1'b1, t};
    tick();
    mis_tag = '0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rdy3 = 1'b1;
    rec_valid = 1'b0; rec_tag = '0; rec_alt_pc = '0; cdb = '0; mis_tag = '0;
    tick();
    tick();
    rst = 1'b0;
    rdy3 = 1'b0;

    chk_ctl("reset", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("reset", 3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.pc", pc1, 32'd0);
    chk("reset.cnt", 32'(cnt1), 32'd0);
    chk("reset.cnt3", 32'(cnt3), 32'd0);

    mispredict(4'd3);
    chk_ctl("orphan_empty", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("orphan_end", 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic accept: record, resolve, mispredict one cycle after the CDB.
    record(4'd5, 32'h0000_1040);
    resolve(4'd5);
    exp_q.push_back(32'h0000_1040);
    mispredict(4'd5);
    chk("cnt.first", 32'(cnt1), 32'd1);
    check_seq(1, 1);
    chk("pc_hold", pc1, 32'h0000_1040);

    // Mispredict two cycles after the CDB finds the entry already aged out.
    record(4'd5, 32'h0000_2040);
    resolve(4'd5);
    tick();
    mispredict(4'd5);
    chk_ctl("late_mis", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("late_cnt", 32'(cnt1), 32'd1);
    resolve(4'd5);
    mispredict(4'd5);
    chk_ctl("empty_cdb", 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Same-cycle record and CDB on a PENDING entry: record wins.
    record(4'd7, 32'h0000_7000);
    rec_valid = 1'b1; rec_tag = 4'd7; rec_alt_pc = 32'h0000_7700; cdb = cdb_word(4'd7);
    tick();
    rec_valid = 1'b0; cdb = '0;
    mispredict(4'd7);
    chk_ctl("rec_wins", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    resolve(4'd7);
    exp_q.push_back(32'h0000_7700);
    mispredict(4'd7);
    chk("cnt7", 32'(cnt1), 32'd2);
    check_seq(1, 1);

    // rdy low in FLUSH freezes everything, with noise on the inputs.
    record(4'd4, 32'h0000_4444);
    resolve(4'd4);
    exp_q.push_back(32'h0000_4444);
    mispredict(4'd4);
    rdy = 1'b0;
    rec_valid = 1'b1; rec_tag = 4'd4; rec_alt_pc = 32'hdead_beef; cdb = cdb_word(4'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_ctl("frozen", 1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("frozen_cnt", 32'(cnt1), 32'd3);
    end
    rec_valid = 1'b0; cdb = '0; rdy = 1'b1;
    check_seq(1, 1);
    chk("cnt_after_freeze", 32'(cnt1), 32'd3);

    // FLUSH_CYCLES=3 instance; the others are frozen meanwhile.
    rdy = 1'b0; rdy3 = 1'b1;
    record(4'd1, 32'h0000_1111);
    record(4'd2, 32'h0000_2222);
    resolve(4'd1);
    exp_q.push_back(32'h0000_1111);
    mis_tag = 5'h11;
    tick();
    mis_tag = 5'h12;
    check_seq(3, 3);
    mis_tag = '0;
    chk("cnt3", 32'(cnt3), 32'd1);
    resolve(4'd2);
    mispredict(4'd2);
    chk_ctl("tag2_empty", 3, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cnt3_after", 32'(cnt3), 32'd1);
    chk("main_frozen_pc", pc1, 32'h0000_4444);
    rdy3 = 1'b0; rdy = 1'b1;
    tick();

    // Saturation on the 4-bit counter instance: 3 + 16 accepts.
    for (int i = 0; i < 16; i++) begin
      record(4'd9, 32'h0000_9000 + 32'(i));
      resolve(4'd9);
      exp_q.push_back(32'h0000_9000 + 32'(i));
      mispredict(4'd9);
      check_seq(1, 1);
    end
    chk("cnt_main", 32'(cnt1), 32'd19);
    chk("cnt_sat", 32'(cnts), 32'd15);

    // Reset during REDIRECT.
    record(4'd6, 32'h0000_6666);
    resolve(4'd6);
    mispredict(4'd6);
    tick();
    chk("in_redirect", 32'(rv1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_ctl("rst_redirect", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    chk("rst_pc", pc1, 32'd0);
    resolve(4'd6);
    mispredict(4'd6);
    chk_ctl("rst_table", 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset clears a PENDING entry.
    record(4'd10, 32'h0000_aaaa);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resolve(4'd10);
    mispredict(4'd10);
    chk_ctl("rst_clears", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_clears_cnt", 32'(cnt1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_recovery_unit.md
Name: branch_recovery_unit

Overview:
- Consumer of the predictor's registered mispredict tag ({valid, tag}, 5 bits).
- Records the alternate (not-predicted) PC per tag at issue and tracks branch resolution on the CDB.
- On a mispredict, runs a flush/redirect sequence that drives the pipeline-wide flush and re-steers fetch to the stored alternate PC.
- Sits between the predictor and the instruction fetch unit.

Parameters:
- TAG_W, 4, tag width; table depth is 2**TAG_W = 16 entries, indexed directly by tag.
- FLUSH_CYCLES, 1, number of cycles `flush` is held high (1..7).
- CNT_W, 16, width of the saturating mispredict counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when low, all state and outputs hold.
- rec_valid  in  1  issue records a predicted branch this cycle.
- rec_tag  in  4  tag of the recorded branch.
- rec_alt_pc  in  32  PC of the not-predicted path.
- cdb  in  74  common data bus; [36] valid, [35:32] tag, [31:0] value.
- mis_tag  in  5  from predictor; [4] mispredict valid, [3:0] tag.
- flush  out  1  pipeline flush, registered.
- fetch_stall  out  1  fetch must not issue, registered.
- redirect_valid  out  1  one-cycle pulse; fetch loads `redirect_pc`.
- redirect_pc  out  32  redirect target, valid with `redirect_valid`.
- mispredict_count  out  CNT_W  accepted mispredicts, saturating.
- orphan_mis  out  1  one-cycle pulse when a mispredict tag has no RESOLVED entry.

Behaviour:
- Reset values: all outputs 0; every entry EMPTY; FSM in IDLE; flush-length counter 0.
- `rdy` low: nothing updates, including entry aging and the FSM; outputs hold their values.
- Entry state, per tag: EMPTY, PENDING or RESOLVED, plus a 32-bit alt_pc.
- Record (IDLE only): `rec_valid` sets entry[`rec_tag`] to PENDING and alt_pc to `rec_alt_pc`. This overwrites an entry in any state.
- CDB resolve: when `cdb[36]` is high and entry[`cdb[35:32]`] is PENDING, the entry becomes RESOLVED.
- Same tag recorded and resolved in one cycle: the record wins and the entry ends PENDING.
- RESOLVED lifetime is exactly one cycle, because the predictor's mispredict tag lags the CDB by one cycle.
  - On the next cycle the entry becomes EMPTY, unless a record overwrites it in that cycle.
- Mispredict accept (IDLE only): requires `mis_tag[4]` high and entry[`mis_tag[3:0]`] RESOLVED.
  - Latch that entry's alt_pc into `redirect_pc`.
  - Increment `mispredict_count`, saturating at all-ones.
  - Go to FLUSH.
- Mispredict with the entry EMPTY or PENDING, in IDLE: pulse `orphan_mis` for one cycle; no state change.
- `mis_tag` while not IDLE: ignored, with no `orphan_mis` pulse.
- FSM state IDLE:
  - `flush` = 0, `fetch_stall` = 0.
  - An accepted mispredict moves to FLUSH on the next edge.
- FSM state FLUSH:
  - `flush` = 1 and `fetch_stall` = 1 for exactly FLUSH_CYCLES cycles.
  - On the first FLUSH cycle every entry goes EMPTY.
  - Records and CDB resolves are ignored for the whole of FLUSH.
  - After FLUSH_CYCLES cycles, go to REDIRECT.
- FSM state REDIRECT:
  - One cycle: `redirect_valid` = 1, `fetch_stall` = 1, `flush` = 0.
  - Records are ignored.
  - Then go to IDLE.
- Latency: a mispredict sampled at edge N gives `flush` high from cycle N+1 through N+FLUSH_CYCLES, and `redirect_valid` high at cycle N+FLUSH_CYCLES+1.
- Mispredict and record in the same IDLE cycle: both take effect. The record is then discarded by the flush clear.
- Reset mid-sequence: returns to IDLE immediately with `flush` and `redirect_valid` dropped.
- `redirect_pc` holds its last value outside REDIRECT.

Test Plan:
- Reset with `rdy` = 1 -> all outputs 0; a mispredict on tag 3 gives `orphan_mis` = 1 for one cycle and `flush` stays 0.
- Record tag 5 with alt 0x0000_1040; CDB on tag 5, value 1; predictor tag 5'h15 the next cycle -> `flush` = 1 for 1 cycle, then `redirect_valid` = 1 with `redirect_pc` = 0x1040; `mispredict_count` = 1; `fetch_stall` high for 2 cycles.
- Same as the previous scenario but the mispredict arrives 2 cycles after the CDB -> `orphan_mis` pulse, no flush, entry 5 EMPTY.
- FLUSH_CYCLES = 3: record tags 1 and 2; resolve and mispredict tag 1 -> `flush` high for 3 cycles; a mispredict on tag 2 during FLUSH is ignored; afterwards tag 2 is EMPTY and a CDB on tag 2 has no effect.
- Same-cycle record and CDB on tag 7 -> entry PENDING; a mispredict on tag 7 the next cycle -> `orphan_mis`.
- Drop `rdy` for 4 cycles while in FLUSH -> `flush` and all state frozen; the sequence completes unchanged once `rdy` returns to 1.
- Force `mispredict_count` to all-ones by 65,535 accepted mispredicts, then one more -> it stays 0xFFFF.
- Assert `rst` during REDIRECT -> next cycle `redirect_valid` = 0, `fetch_stall` = 0, table empty.
